// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester APB master with round-robin arbitration.
// One transfer at a time, IDLE -> SETUP -> ACCESS, with an ACCESS-phase timeout
// and a two-bit address decode onto four slave selects.
module apb_rr_master #(
  parameter int width   = 32,
  parameter int DEC_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  // requester 0
  input  logic             m0_valid,
  input  logic             m0_write,
  input  logic [width-1:0] m0_addr,
  input  logic [width-1:0] m0_wdata,
  output logic             m0_ready,
  output logic             m0_done,
  output logic [width-1:0] m0_rdata,
  output logic             m0_err,
  // requester 1
  input  logic             m1_valid,
  input  logic             m1_write,
  input  logic [width-1:0] m1_addr,
  input  logic [width-1:0] m1_wdata,
  output logic             m1_ready,
  output logic             m1_done,
  output logic [width-1:0] m1_rdata,
  output logic             m1_err,
  // APB bus side
  output logic [width-1:0] addr,
  output logic [width-1:0] data,
  output logic             write,
  output logic             enable,
  output logic             sel1,
  output logic             sel2,
  output logic             sel3,
  output logic             sel4,
  input  logic [width-1:0] PRDATA,
  input  logic             PREADY,
  input  logic             PSLVERR
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Slave-select decode of the two-bit field: 00->sel1 .. 11->sel4.
  function automatic logic [3:0] sel_decode(input logic [1:0] field);
    logic [3:0] onehot;
    case (field)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  state_e           state_q, state_d;
  logic             last_q, last_d;      // last granted requester; also owner of the live transfer
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] addr_q, addr_d;
  logic [width-1:0] data_q, data_d;
  logic             write_q, write_d;
  logic             enable_q, enable_d;
  logic [3:0]       sel_q, sel_d;
  logic             m0_done_q, m0_done_d;
  logic             m0_err_q, m0_err_d;
  logic [width-1:0] m0_rdata_q, m0_rdata_d;
  logic             m1_done_q, m1_done_d;
  logic             m1_err_q, m1_err_d;
  logic [width-1:0] m1_rdata_q, m1_rdata_d;

  logic             gnt0, gnt1;
  logic             fin;
  logic             fin_err;
  logic [width-1:0] fin_rdata;

  // Round-robin grant and the combinational accept strobes (IDLE only).
  always_comb begin
    gnt0     = m0_valid & (~m1_valid | last_q);
    gnt1     = m1_valid & (~m0_valid | ~last_q);
    m0_ready = (state_q == IDLE) & gnt0;
    m1_ready = (state_q == IDLE) & gnt1;
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    write_d    = write_q;
    enable_d   = enable_q;
    sel_d      = sel_q;
    m0_done_d  = 1'b0;
    m0_err_d   = m0_err_q;
    m0_rdata_d = m0_rdata_q;
    m1_done_d  = 1'b0;
    m1_err_d   = m1_err_q;
    m1_rdata_d = m1_rdata_q;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = {width{1'b0}};

    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          last_d   = gnt1;
          addr_d   = gnt1 ? m1_addr : m0_addr;
          data_d   = gnt1 ? m1_wdata : m0_wdata;
          write_d  = gnt1 ? m1_write : m0_write;
          sel_d    = sel_decode(gnt1 ? m1_addr[DEC_LSB+1:DEC_LSB] : m0_addr[DEC_LSB+1:DEC_LSB]);
          enable_d = 1'b0;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        enable_d = 1'b1;
        cnt_d    = {CNT_W{1'b0}};
        state_d  = ACCESS;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing in the same cycle.
        if (PREADY) begin
          fin       = 1'b1;
          fin_err   = PSLVERR;
          fin_rdata = write_q ? {width{1'b0}} : PRDATA;
        end else if (cnt_q == CNT_LAST) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = {width{1'b0}};
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        sel_d    = 4'b0000;
      end
    endcase

    if (fin) begin
      sel_d    = 4'b0000;
      enable_d = 1'b0;
      state_d  = IDLE;
      if (last_q) begin
        m1_done_d  = 1'b1;
        m1_err_d   = fin_err;
        m1_rdata_d = fin_rdata;
      end else begin
        m0_done_d  = 1'b1;
        m0_err_d   = fin_err;
        m0_rdata_d = fin_rdata;
      end
    end else begin
      m0_done_d = 1'b0;
      m1_done_d = 1'b0;
    end
  end

  // State and output registers; PRESETn is a synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= {CNT_W{1'b0}};
      addr_q     <= {width{1'b0}};
      data_q     <= {width{1'b0}};
      write_q    <= 1'b0;
      enable_q   <= 1'b0;
      sel_q      <= 4'b0000;
      m0_done_q  <= 1'b0;
      m0_err_q   <= 1'b0;
      m0_rdata_q <= {width{1'b0}};
      m1_done_q  <= 1'b0;
      m1_err_q   <= 1'b0;
      m1_rdata_q <= {width{1'b0}};
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      enable_q   <= enable_d;
      sel_q      <= sel_d;
      m0_done_q  <= m0_done_d;
      m0_err_q   <= m0_err_d;
      m0_rdata_q <= m0_rdata_d;
      m1_done_q  <= m1_done_d;
      m1_err_q   <= m1_err_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign addr     = addr_q;
  assign data     = data_q;
  assign write    = write_q;
  assign enable   = enable_q;
  assign sel1     = sel_q[0];
  assign sel2     = sel_q[1];
  assign sel3     = sel_q[2];
  assign sel4     = sel_q[3];
  assign m0_done  = m0_done_q;
  assign m0_err   = m0_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_done  = m1_done_q;
  assign m1_err   = m1_err_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed scenarios plus randomized traffic, checked against a
// transaction-level model (grant rule + arithmetic cycle schedule per transfer).
module tb_apb_rr_master;
  localparam int W  = 32;
  localparam int DL = 12;
  localparam int TO = 16;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         m0_valid, m0_write, m0_ready, m0_done, m0_err;
  logic [W-1:0] m0_addr, m0_wdata, m0_rdata;
  logic         m1_valid, m1_write, m1_ready, m1_done, m1_err;
  logic [W-1:0] m1_addr, m1_wdata, m1_rdata;
  logic [W-1:0] addr, data, PRDATA;
  logic         write, enable, sel1, sel2, sel3, sel4, PREADY, PSLVERR;

  apb_rr_master #(.width(W), .DEC_LSB(DL), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .addr(addr), .data(data), .write(write), .enable(enable),
    .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester model
  logic         pend [2];
  logic         rq_wr [2];
  logic [W-1:0] rq_addr [2];
  logic [W-1:0] rq_wdata [2];
  // arbitration history and live transfer
  int           last_g;
  bit           busy;
  int           k, e_len, cur, ws;
  logic         s_err, tmo;
  logic [W-1:0] s_rdata;
  logic [W-1:0] b_addr, b_data;
  logic         b_wr;
  logic [3:0]   b_sel;
  int           grants[$];
  // stimulus knobs
  bit           auto_req;
  int           req_pct;
  bit           rand_slave;
  int           f_ws;
  logic         f_err;
  logic [W-1:0] f_rdata;
  int           rst_cycles;

  task automatic load_req(input int i, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
    pend[i] = 1'b1; rq_wr[i] = wr; rq_addr[i] = a; rq_wdata[i] = d;
  endtask

  task automatic model_reset();
    busy = 0; k = 0; last_g = 1;
    b_addr = '0; b_data = '0; b_wr = 1'b0; b_sel = 4'b0000;
  endtask

  // One clock: check registered outputs, drive inputs, check the accept strobes.
  task automatic step();
    logic [69:0]  exp_bus;
    logic [1:0]   exp_done;
    logic [1:0]   exp_rdy;
    logic [W-1:0] exp_rd;
    logic [W-1:0] a_tmp;
    int           g;
    bit           rs;
    rs = (PRESETn === 1'b1);
    exp_done = 2'b00;
    if (rs) begin
      model_reset();
      exp_bus = '0;
    end else begin
      if (busy) k++;
      if (busy && k == 1)
        exp_bus = {b_addr, b_data, b_wr, 1'b0, b_sel};
      else if (busy && k >= 2 && k <= e_len + 1)
        exp_bus = {b_addr, b_data, b_wr, 1'b1, b_sel};
      else
        exp_bus = {b_addr, b_data, b_wr, 1'b0, 4'b0000};
      if (busy && k == e_len + 2) begin
        exp_done[cur] = 1'b1;
        exp_rd = (tmo || b_wr) ? '0 : s_rdata;
        check_val("rdata", cur ? m1_rdata : m0_rdata, exp_rd);
        check_val("err", cur ? m1_err : m0_err, tmo ? 1'b1 : s_err);
        busy = 0;
      end
    end
    check_val("bus", {addr, data, write, enable, sel4, sel3, sel2, sel1}, exp_bus);
    check_val("done", {m1_done, m0_done}, exp_done);

    // drive inputs for this cycle
    PRESETn = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    for (int i = 0; i < 2; i++) begin
      if (auto_req && !pend[i] && ($urandom_range(0, 99) < req_pct)) begin
        a_tmp = $urandom;
        load_req(i, 1'($urandom_range(0, 1)), a_tmp, $urandom);
      end
    end
    m0_valid = pend[0]; m0_write = rq_wr[0]; m0_addr = rq_addr[0]; m0_wdata = rq_wdata[0];
    m1_valid = pend[1]; m1_write = rq_wr[1]; m1_addr = rq_addr[1]; m1_wdata = rq_wdata[1];
    if (busy && k >= 2 && (k - 2) == ws) begin
      PREADY = 1'b1; PSLVERR = s_err; PRDATA = s_rdata;
    end else if (busy && k >= 1) begin
      PREADY = 1'b0; PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    end else begin
      PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
    end

    #1;
    if (PRESETn !== 1'b1) begin
      exp_rdy = 2'b00;
      g = -1;
      if (!busy) begin
        if (pend[0] && pend[1]) g = (last_g == 0) ? 1 : 0;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("ready", {m1_ready, m0_ready}, exp_rdy);
      if (g >= 0) begin
        busy = 1; k = 0; cur = g; last_g = g; pend[g] = 1'b0;
        b_addr = rq_addr[g]; b_data = rq_wdata[g]; b_wr = rq_wr[g];
        a_tmp = rq_addr[g];
        b_sel = 4'b0001 << a_tmp[DL+1:DL];
        if (rand_slave) begin
          ws = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
          s_err = 1'($urandom_range(0, 3) == 0); s_rdata = $urandom;
        end else begin
          ws = f_ws; s_err = f_err; s_rdata = f_rdata;
        end
        tmo   = (ws >= TO);
        e_len = tmo ? TO : ws + 1;
        grants.push_back(g);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      step();
    end
  endtask

  initial begin
    int guard;
    PRESETn = 1'b1; rst_cycles = 2;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rq_wr[0] = 1'b0; rq_wr[1] = 1'b0;
    rq_addr[0] = '0; rq_addr[1] = '0; rq_wdata[0] = '0; rq_wdata[1] = '0;
    m0_valid = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    auto_req = 0; req_pct = 0; rand_slave = 0; f_ws = 0; f_err = 1'b0; f_rdata = '0;
    model_reset();
    run(4);

    // m0 write, zero wait states
    load_req(0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    run(6);
    // m1 read, three wait states
    f_ws = 3; f_rdata = 32'h1234_5678;
    load_req(1, 1'b0, 32'h0000_3010, 32'h0);
    run(9);
    // timeout with PREADY held low
    f_ws = 1000; f_rdata = 32'hFFFF_FFFF;
    load_req(0, 1'b0, 32'h0000_0040, 32'h0);
    run(22);
    // slave error on a read
    f_ws = 0; f_err = 1'b1; f_rdata = 32'hA5A5_A5A5;
    load_req(1, 1'b0, 32'h0000_2000, 32'h0);
    run(6);

    // both requesters hammering: strict alternation
    f_err = 1'b0; f_rdata = 32'h0BAD_F00D;
    grants.delete();
    auto_req = 1; req_pct = 100;
    run(16);
    for (int i = 0; i < 4; i++)
      check_val("rr_order", (grants.size() > i) ? grants[i] : -1, i % 2);

    // reset in the middle of ACCESS, then m0 must win first
    f_ws = 6;
    guard = 0;
    while (!(busy && k == 2) && guard < 50) begin
      run(1);
      guard++;
    end
    check_val("reach_access", guard < 50, 1'b1);
    rst_cycles = 1;
    run(1);
    grants.delete();
    run(3);
    check_val("post_rst_first", (grants.size() > 0) ? grants[0] : -1, 0);
    run(12);

    // randomized traffic with occasional resets
    rand_slave = 1; req_pct = 35;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) rst_cycles = $urandom_range(1, 2);
      run(1);
    end
    auto_req = 0;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
